// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the IF/DM memory arbiter
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_lat_ctr.sv
// rtl/mem_lat_ctr.sv - loadable down-counter with zero flag for fixed-latency memory users
module mem_lat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port fixed-latency memory sequencer shared by fetch and data stages
// Optional IF starvation aging is built when IF_AGING_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 4
`ifdef IF_AGING_EN
    , parameter int STARVE_MAX = 3
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_done,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t  state, state_nxt;
    owner_t      winner;
    logic        force_if;
    logic        kill_q;
    logic        acc_wr_q;
    logic [15:0] if_rdata_q, dm_rdata_q;
    logic        ctr_load, ctr_dec, cnt_zero;

    mem_lat_ctr #(.W(CNT_W)) u_lat_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load),
        .load_val (LAT_LOAD),
        .dec      (ctr_dec),
        .zero     (cnt_zero)
    );

`ifdef IF_AGING_EN
    localparam int STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve;

    assign force_if = if_req && (starve == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (if_gnt) begin
            starve <= '0;
        end else if (dm_gnt && if_req && (starve != STARVE_W'(STARVE_MAX))) begin
            starve <= starve + STARVE_W'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are suppressed while rst_n is low so every output reads 0 during reset.
    always_comb begin
        state_nxt = state;
        winner    = (dm_req && !force_if) ? OWN_DM : OWN_IF;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rst_n && (dm_req || if_req)) begin
                    mem_en   = 1'b1;
                    ctr_load = 1'b1;
                    if (winner == OWN_DM) begin
                        dm_gnt    = 1'b1;
                        mem_wr    = dm_wr;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        state_nxt = ST_BUSY_DM;
                    end else begin
                        if_gnt    = 1'b1;
                        mem_addr  = if_addr;
                        state_nxt = ST_BUSY_IF;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (cnt_zero) begin
                    if_done   = !(kill_q || if_kill);
                    state_nxt = ST_IDLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_BUSY_DM: begin
                if (cnt_zero) begin
                    dm_done   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign err = mem_en && mem_addr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            kill_q     <= 1'b0;
            acc_wr_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (dm_gnt) begin
                acc_wr_q <= dm_wr;
            end
            if (state_nxt == ST_IDLE) begin
                kill_q <= 1'b0;
            end else if (if_kill && (if_gnt || (state == ST_BUSY_IF))) begin
                kill_q <= 1'b1;
            end
            if (if_done) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_done && !acc_wr_q) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data is passed through in the done cycle, then held from the capture register.
    assign if_rdata = if_done ? mem_rdata : if_rdata_q;
    assign dm_rdata = (dm_done && !acc_wr_q) ? mem_rdata : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;

    localparam int LAT = 4;

    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_GIF  = 7'b1000100;
    localparam logic [6:0] F_GIFE = 7'b1000101;
    localparam logic [6:0] F_DIF  = 7'b0100000;
    localparam logic [6:0] F_GDM  = 7'b0010100;
    localparam logic [6:0] F_GDMW = 7'b0010110;
    localparam logic [6:0] F_DDM  = 7'b0001000;

    typedef struct {
        logic        ir;
        logic [15:0] ia;
        logic        dr;
        logic        dw;
        logic [15:0] da;
        logic [15:0] dwd;
        logic [6:0]  fl;
        logic [15:0] ea;
        logic [15:0] ew;
        logic [15:0] eir;
        logic [15:0] edr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_kill, dm_req, dm_wr;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic        if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_wr, err;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_gnt    (if_gnt),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ 0x5A5A exactly LAT cycles after mem_en, 0x0BAD otherwise.
    logic        v_pipe [LAT];
    logic [15:0] a_pipe [LAT];

    initial begin
        for (int i = 0; i < LAT; i++) begin
            v_pipe[i] = 1'b0;
            a_pipe[i] = 16'h0;
        end
    end

    always @(posedge clk) begin
        v_pipe[0] <= mem_en;
        a_pipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            a_pipe[i] <= a_pipe[i-1];
        end
    end

    assign mem_rdata = v_pipe[LAT-1] ? (a_pipe[LAT-1] ^ 16'h5A5A) : 16'h0BAD;

    logic [70:0] obs;
    assign obs = {if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_wr, err,
                  mem_addr, mem_wdata, if_rdata, dm_rdata};

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic ik, input logic dr,
                         input logic dw, input logic [15:0] da, input logic [15:0] dwd);
        if_req   = ir;
        if_addr  = ia;
        if_kill  = ik;
        dm_req   = dr;
        dm_wr    = dw;
        dm_addr  = da;
        dm_wdata = dwd;
    endtask

    task automatic drive0();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic vec_t mkv(input logic ir, input logic [15:0] ia, input logic dr,
                                 input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                                 input logic [6:0] fl, input logic [15:0] ea, input logic [15:0] ew,
                                 input logic [15:0] eir, input logic [15:0] edr);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.fl = fl; v.ea = ea; v.ew = ew; v.eir = eir; v.edr = edr;
        return v;
    endfunction

    // Samples the current cycle first; always advances one cycle per iteration.
    task automatic wait_gnt(output logic gi, output logic gd, output logic ge, output logic ok);
        ok = 1'b0; gi = 1'b0; gd = 1'b0; ge = 1'b0;
        for (int n = 0; n < 15 && !ok; n++) begin
            if (if_gnt || dm_gnt) begin
                gi = if_gnt; gd = dm_gnt; ge = err; ok = 1'b1;
            end
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [$];
        int   dn;
        logic gi, gd, ge, ok, exp_if;

        tbl.push_back(mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, F_GIF, 16'h0010, 16'h0, 16'h0, 16'h0));
        repeat (3) tbl.push_back(mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h0, 16'h0));
        tbl.push_back(mkv(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, F_DIF, 16'h0, 16'h0, 16'h5A4A, 16'h0));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A4A, 16'h0));
        tbl.push_back(mkv(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0100, 16'h0, F_GDM, 16'h0100, 16'h0, 16'h5A4A, 16'h0));
        repeat (3) tbl.push_back(mkv(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0100, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A4A, 16'h0));
        tbl.push_back(mkv(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0100, 16'h0, F_DDM, 16'h0, 16'h0, 16'h5A4A, 16'h5B5A));
        tbl.push_back(mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, F_GIF, 16'h0020, 16'h0, 16'h5A4A, 16'h5B5A));
        repeat (3) tbl.push_back(mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A4A, 16'h5B5A));
        tbl.push_back(mkv(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 16'h0, F_DIF, 16'h0, 16'h0, 16'h5A7A, 16'h5B5A));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A7A, 16'h5B5A));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'hBEEF, F_GDMW, 16'h0200, 16'hBEEF, 16'h5A7A, 16'h5B5A));
        repeat (3) tbl.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A7A, 16'h5B5A));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, F_DDM, 16'h0, 16'h0, 16'h5A7A, 16'h5B5A));
        tbl.push_back(mkv(1'b1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, F_GIFE, 16'h0011, 16'h0, 16'h5A7A, 16'h5B5A));
        repeat (3) tbl.push_back(mkv(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0104, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A7A, 16'h5B5A));
        tbl.push_back(mkv(1'b1, 16'h0011, 1'b1, 1'b0, 16'h0104, 16'h0, F_DIF, 16'h0, 16'h0, 16'h5A4B, 16'h5B5A));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0104, 16'h0, F_GDM, 16'h0104, 16'h0, 16'h5A4B, 16'h5B5A));
        repeat (3) tbl.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0104, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A4B, 16'h5B5A));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b1, 1'b0, 16'h0104, 16'h0, F_DDM, 16'h0, 16'h0, 16'h5A4B, 16'h5B5E));
        tbl.push_back(mkv(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, F_NONE, 16'h0, 16'h0, 16'h5A4B, 16'h5B5E));

        rst_n = 1'b0;
        drive0();
        repeat (2) @(negedge clk);
        #2 chk("reset_outputs", 80'(obs), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].ir, tbl[i].ia, 1'b0, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd);
            #2;
            chk($sformatf("vec%0d", i), 80'(obs),
                80'({tbl[i].fl, tbl[i].ea, tbl[i].ew, tbl[i].eir, tbl[i].edr}));
        end

        // Kill in the middle of an IF access
        @(negedge clk); drive(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 chk("kill_gnt", 80'({if_gnt, mem_addr}), 80'({1'b1, 16'h0030}));
        @(negedge clk);
        @(negedge clk); drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk); drive0();
        @(negedge clk); drive(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 chk("kill_no_done", 80'({if_gnt, if_done, if_rdata}), 80'({1'b0, 1'b0, 16'h5A4B}));
        @(negedge clk);
        #2 chk("kill_idle_t5", 80'({if_gnt, mem_addr}), 80'({1'b1, 16'h0040}));
        repeat (3) @(negedge clk);
        @(negedge clk);
        #2 chk("after_kill_done", 80'({if_done, if_rdata}), 80'({1'b1, 16'h5A1A}));
        @(negedge clk); drive0();

        // Kill in the grant cycle itself
        @(negedge clk); drive(1'b1, 16'h0050, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 chk("gntkill_gnt", 80'(if_gnt), 80'd1);
        @(negedge clk); drive0();
        repeat (2) @(negedge clk);
        @(negedge clk);
        #2 chk("gntkill_no_done", 80'({if_done, if_rdata}), 80'({1'b0, 16'h5A1A}));
        @(negedge clk);

        // Kill during a DM access has no effect on DM or the next IF access
        @(negedge clk); drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0060, 16'h0);
        #2 chk("dmkill_gnt", 80'(dm_gnt), 80'd1);
        @(negedge clk); drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        #2 chk("dmkill_done", 80'({dm_done, dm_rdata}), 80'({1'b1, 16'h5A3A}));
        @(negedge clk); drive(1'b1, 16'h0070, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 chk("if_after_dm_gnt", 80'(if_gnt), 80'd1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        #2 chk("if_after_dm_done", 80'({if_done, if_rdata}), 80'({1'b1, 16'h5A2A}));
        @(negedge clk); drive0();

        // Reset in the middle of a DM access
        @(negedge clk); drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
        #2 chk("rst_dm_gnt", 80'(dm_gnt), 80'd1);
        @(negedge clk); drive(1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
        @(negedge clk); rst_n = 1'b0;
        #2 chk("rst_outputs", 80'(obs), 80'd0);
        @(negedge clk); rst_n = 1'b1; drive0();
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            #2;
            if (dm_done || if_done) dn++;
        end
        chk("rst_no_done", 80'(dn), 80'd0);
        chk("rst_rdata", 80'({if_rdata, dm_rdata}), 80'd0);

        // Both requesters held high: DM priority, with IF aging when built in
        @(negedge clk); drive(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0);
        #2;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(gi, gd, ge, ok);
            chk($sformatf("arb%0d_timeout", k), 80'(ok), 80'd1);
`ifdef IF_AGING_EN
            exp_if = (k == 3);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("arb%0d_winner", k), 80'({gi, gd, ge}),
                80'(exp_if ? 3'b101 : 3'b010));
        end
        @(negedge clk); drive0();
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
